// File: rtl/dq_dispatch_ctrl.sv
// Dispatch allocation controller: one-entry group skid register with per-queue credit counters.
// Optional stall counter (o_stall_cnt) is built when DQ_DISPATCH_PERF_EN is defined.
module dq_dispatch_ctrl #(
    parameter int  INPORT_NUM = 4,
    parameter int  ROB_DEPTH  = 32,
    parameter int  IMM_DEPTH  = 16,
    parameter int  BRU_DEPTH  = 16,
    localparam int CNT_W      = $clog2(INPORT_NUM + 1),
    localparam int ROB_W      = $clog2(ROB_DEPTH + 1),
    localparam int IMM_W      = $clog2(IMM_DEPTH + 1),
    localparam int BRU_W      = $clog2(BRU_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_in_vld,
    output logic                  o_in_rdy,
    input  logic [INPORT_NUM-1:0] i_in_req,
    input  logic [INPORT_NUM-1:0] i_in_use_imm,
    input  logic [INPORT_NUM-1:0] i_in_use_bru,
    output logic                  o_enq_vld,
    output logic [INPORT_NUM-1:0] o_rob_enq_req,
    output logic [INPORT_NUM-1:0] o_imm_enq_req,
    output logic [INPORT_NUM-1:0] o_bru_enq_req,
    input  logic [CNT_W-1:0]      i_rob_clear_num,
    input  logic [CNT_W-1:0]      i_imm_clear_num,
    input  logic [CNT_W-1:0]      i_bru_clear_num,
    output logic [ROB_W-1:0]      o_rob_free,
    output logic [IMM_W-1:0]      o_imm_free,
    output logic [BRU_W-1:0]      o_bru_free,
    output logic                  o_stall
`ifdef DQ_DISPATCH_PERF_EN
    ,
    output logic [31:0]           o_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [ROB_W-1:0] ROB_FULL = ROB_W'(ROB_DEPTH);
    localparam logic [IMM_W-1:0] IMM_FULL = IMM_W'(IMM_DEPTH);
    localparam logic [BRU_W-1:0] BRU_FULL = BRU_W'(BRU_DEPTH);

    function automatic logic [CNT_W-1:0] popcnt(input logic [INPORT_NUM-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int k = 0; k < INPORT_NUM; k++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[k]};
        end
        return c;
    endfunction

    state_e                 state_q, state_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [INPORT_NUM-1:0]  rob_mask_q, rob_mask_d;
    logic [INPORT_NUM-1:0]  imm_mask_q, imm_mask_d;
    logic [INPORT_NUM-1:0]  bru_mask_q, bru_mask_d;
    logic [ROB_W-1:0]       rob_free_q, rob_free_d;
    logic [IMM_W-1:0]       imm_free_q, imm_free_d;
    logic [BRU_W-1:0]       bru_free_q, bru_free_d;

    logic [CNT_W-1:0]       rob_need_s, imm_need_s, bru_need_s;
    logic [ROB_W:0]         rob_sum_s;
    logic [IMM_W:0]         imm_sum_s;
    logic [BRU_W:0]         bru_sum_s;
    logic                   credit_ok_s, credits_full_s;
    logic                   fire_s, in_rdy_s, accept_s;

    assign rob_need_s = popcnt(rob_mask_q);
    assign imm_need_s = popcnt(imm_mask_q);
    assign bru_need_s = popcnt(bru_mask_q);

    // Sufficiency looks only at registered credit; returns this cycle count from the next one.
    assign credit_ok_s = ({{(ROB_W+1-CNT_W){1'b0}}, rob_need_s} <= {1'b0, rob_free_q}) &&
                         ({{(IMM_W+1-CNT_W){1'b0}}, imm_need_s} <= {1'b0, imm_free_q}) &&
                         ({{(BRU_W+1-CNT_W){1'b0}}, bru_need_s} <= {1'b0, bru_free_q});
    assign credits_full_s = (rob_free_q == ROB_FULL) && (imm_free_q == IMM_FULL) &&
                            (bru_free_q == BRU_FULL);

    // Controller state transition plus fire / ready decode.
    always_comb begin
        state_d  = state_q;
        fire_s   = 1'b0;
        in_rdy_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                fire_s   = hold_vld_q & ~i_flush & credit_ok_s;
                in_rdy_s = ~i_flush & (~hold_vld_q | fire_s);
            end
            ST_DRAIN: begin
                if (credits_full_s && !i_flush) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
        if (i_flush) begin
            state_d = ST_DRAIN;
        end else begin
            state_d = state_d;
        end
    end

    assign accept_s = i_in_vld & in_rdy_s;

    // Skid register: flush drops the group, accept replaces it, a lone fire empties it.
    always_comb begin
        hold_vld_d = hold_vld_q;
        rob_mask_d = rob_mask_q;
        imm_mask_d = imm_mask_q;
        bru_mask_d = bru_mask_q;
        if (i_flush || (fire_s && !accept_s)) begin
            hold_vld_d = 1'b0;
            rob_mask_d = {INPORT_NUM{1'b0}};
            imm_mask_d = {INPORT_NUM{1'b0}};
            bru_mask_d = {INPORT_NUM{1'b0}};
        end else if (accept_s) begin
            hold_vld_d = 1'b1;
            rob_mask_d = i_in_req;
            imm_mask_d = i_in_req & i_in_use_imm;
            bru_mask_d = i_in_req & i_in_use_bru;
        end else begin
            hold_vld_d = hold_vld_q;
        end
    end

    // One extra bit so the range assertions can see under/overflow before truncation.
    assign rob_sum_s = {1'b0, rob_free_q}
                     - (fire_s ? {{(ROB_W+1-CNT_W){1'b0}}, rob_need_s} : {(ROB_W+1){1'b0}})
                     + {{(ROB_W+1-CNT_W){1'b0}}, i_rob_clear_num};
    assign imm_sum_s = {1'b0, imm_free_q}
                     - (fire_s ? {{(IMM_W+1-CNT_W){1'b0}}, imm_need_s} : {(IMM_W+1){1'b0}})
                     + {{(IMM_W+1-CNT_W){1'b0}}, i_imm_clear_num};
    assign bru_sum_s = {1'b0, bru_free_q}
                     - (fire_s ? {{(BRU_W+1-CNT_W){1'b0}}, bru_need_s} : {(BRU_W+1){1'b0}})
                     + {{(BRU_W+1-CNT_W){1'b0}}, i_bru_clear_num};
    assign rob_free_d = rob_sum_s[ROB_W-1:0];
    assign imm_free_d = imm_sum_s[IMM_W-1:0];
    assign bru_free_d = bru_sum_s[BRU_W-1:0];

    // State, skid register and credit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            hold_vld_q <= 1'b0;
            rob_mask_q <= {INPORT_NUM{1'b0}};
            imm_mask_q <= {INPORT_NUM{1'b0}};
            bru_mask_q <= {INPORT_NUM{1'b0}};
            rob_free_q <= ROB_FULL;
            imm_free_q <= IMM_FULL;
            bru_free_q <= BRU_FULL;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            rob_mask_q <= rob_mask_d;
            imm_mask_q <= imm_mask_d;
            bru_mask_q <= bru_mask_d;
            rob_free_q <= rob_free_d;
            imm_free_q <= imm_free_d;
            bru_free_q <= bru_free_d;
        end
    end

    assign o_in_rdy      = in_rdy_s & ~rst;
    assign o_enq_vld     = fire_s;
    assign o_rob_enq_req = rob_mask_q;
    assign o_imm_enq_req = imm_mask_q;
    assign o_bru_enq_req = bru_mask_q;
    assign o_rob_free    = rob_free_q;
    assign o_imm_free    = imm_free_q;
    assign o_bru_free    = bru_free_q;
    assign o_stall       = hold_vld_q & ~fire_s;

`ifdef DQ_DISPATCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles while running.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && (state_q == ST_RUN) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

    a_rob_credit_range: assert property (@(posedge clk) disable iff (rst) rob_sum_s <= {1'b0, ROB_FULL});
    a_imm_credit_range: assert property (@(posedge clk) disable iff (rst) imm_sum_s <= {1'b0, IMM_FULL});
    a_bru_credit_range: assert property (@(posedge clk) disable iff (rst) bru_sum_s <= {1'b0, BRU_FULL});

endmodule

// File: tb/tb_dq_dispatch_ctrl.sv
// Scoreboard bench for dq_dispatch_ctrl: groups queued on accept, compared on enqueue,
// with a per-cycle credit/handshake model plus directed checks from the test plan.
module tb_dq_dispatch_ctrl;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int RW = 6;
    localparam int IW = 5;
    localparam int BW = 5;
    localparam int ROB_D = 32;
    localparam int IMM_D = 16;
    localparam int BRU_D = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flush, i_in_vld, o_in_rdy, o_enq_vld, o_stall;
    logic [N-1:0]  i_in_req, i_in_use_imm, i_in_use_bru;
    logic [N-1:0]  o_rob_enq_req, o_imm_enq_req, o_bru_enq_req;
    logic [CW-1:0] i_rob_clear_num, i_imm_clear_num, i_bru_clear_num;
    logic [RW-1:0] o_rob_free;
    logic [IW-1:0] o_imm_free;
    logic [BW-1:0] o_bru_free;
`ifdef DQ_DISPATCH_PERF_EN
    logic [31:0]   o_stall_cnt;
`endif

    dq_dispatch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_in_vld        (i_in_vld),
        .o_in_rdy        (o_in_rdy),
        .i_in_req        (i_in_req),
        .i_in_use_imm    (i_in_use_imm),
        .i_in_use_bru    (i_in_use_bru),
        .o_enq_vld       (o_enq_vld),
        .o_rob_enq_req   (o_rob_enq_req),
        .o_imm_enq_req   (o_imm_enq_req),
        .o_bru_enq_req   (o_bru_enq_req),
        .i_rob_clear_num (i_rob_clear_num),
        .i_imm_clear_num (i_imm_clear_num),
        .i_bru_clear_num (i_bru_clear_num),
        .o_rob_free      (o_rob_free),
        .o_imm_free      (o_imm_free),
        .o_bru_free      (o_bru_free),
        .o_stall         (o_stall)
`ifdef DQ_DISPATCH_PERF_EN
        ,
        .o_stall_cnt     (o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] rob;
        logic [N-1:0] imm;
        logic [N-1:0] bru;
    } grp_t;

    grp_t        sb_q[$];
    grp_t        front;
    int          m_rob, m_imm, m_bru;
    bit          m_drain, have, exp_fire, exp_rdy, exp_stall, full_old;
    int          nr, ni, nb;
    logic [31:0] m_scnt;

    // Reference model: evaluated mid-cycle, then advanced to the next cycle's state.
    always @(negedge clk) begin
        if (rst) begin
            m_rob = ROB_D; m_imm = IMM_D; m_bru = BRU_D;
            m_drain = 1'b0; m_scnt = 32'd0;
            sb_q.delete();
        end else begin
            have = (sb_q.size() != 0);
            nr = 0; ni = 0; nb = 0;
            if (have) begin
                front = sb_q[0];
                nr = $countones(front.rob);
                ni = $countones(front.imm);
                nb = $countones(front.bru);
            end
            exp_fire  = have && !i_flush && !m_drain && nr <= m_rob && ni <= m_imm && nb <= m_bru;
            exp_rdy   = !m_drain && !i_flush && (!have || exp_fire);
            exp_stall = have && !exp_fire;
            chk("rob_free", 64'(o_rob_free), 64'(m_rob));
            chk("imm_free", 64'(o_imm_free), 64'(m_imm));
            chk("bru_free", 64'(o_bru_free), 64'(m_bru));
            chk("enq_vld", 64'(o_enq_vld), 64'(exp_fire));
            chk("in_rdy", 64'(o_in_rdy), 64'(exp_rdy));
            chk("stall", 64'(o_stall), 64'(exp_stall));
            if (exp_fire) begin
                chk("rob_mask", 64'(o_rob_enq_req), 64'(front.rob));
                chk("imm_mask", 64'(o_imm_enq_req), 64'(front.imm));
                chk("bru_mask", 64'(o_bru_enq_req), 64'(front.bru));
                void'(sb_q.pop_front());
            end
`ifdef DQ_DISPATCH_PERF_EN
            chk("stall_cnt", 64'(o_stall_cnt), 64'(m_scnt));
            if (exp_stall && !m_drain && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
`endif
            full_old = (m_rob == ROB_D) && (m_imm == IMM_D) && (m_bru == BRU_D);
            m_rob = m_rob - (exp_fire ? nr : 0) + int'(i_rob_clear_num);
            m_imm = m_imm - (exp_fire ? ni : 0) + int'(i_imm_clear_num);
            m_bru = m_bru - (exp_fire ? nb : 0) + int'(i_bru_clear_num);
            if (i_flush) begin
                m_drain = 1'b1;
                sb_q.delete();
            end else if (m_drain && full_old) begin
                m_drain = 1'b0;
            end
            if (i_in_vld && exp_rdy) begin
                sb_q.push_back('{rob: i_in_req, imm: i_in_req & i_in_use_imm,
                                 bru: i_in_req & i_in_use_bru});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_grp(input logic vld, input logic [N-1:0] req,
                             input logic [N-1:0] imm, input logic [N-1:0] bru);
        i_in_vld     = vld;
        i_in_req     = req;
        i_in_use_imm = imm;
        i_in_use_bru = bru;
    endtask

    // Return outstanding entries (up to 4 per queue per cycle) until all credits are full.
    task automatic give_back();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (m_rob == ROB_D && m_imm == IMM_D && m_bru == BRU_D) begin
                done = 1'b1;
                break;
            end
            i_rob_clear_num = CW'((ROB_D - m_rob) > 4 ? 4 : (ROB_D - m_rob));
            i_imm_clear_num = CW'((IMM_D - m_imm) > 4 ? 4 : (IMM_D - m_imm));
            i_bru_clear_num = CW'((BRU_D - m_bru) > 4 ? 4 : (BRU_D - m_bru));
            tick();
        end
        i_rob_clear_num = '0;
        i_imm_clear_num = '0;
        i_bru_clear_num = '0;
        chk("give_back_done", 64'(done), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int fires, stalls;

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        drive_grp(1'b0, '0, '0, '0);
        i_rob_clear_num = '0; i_imm_clear_num = '0; i_bru_clear_num = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", 64'(o_in_rdy), 64'd0);
        chk("rst_rob_free", 64'(o_rob_free), 64'd32);
        chk("rst_imm_free", 64'(o_imm_free), 64'd16);
        chk("rst_bru_free", 64'(o_bru_free), 64'd16);
        chk("rst_enq_vld", 64'(o_enq_vld), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);
        chk("rst_rob_mask", 64'(o_rob_enq_req), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(o_in_rdy), 64'd1);

        // Basic group: accept in cycle 0, enqueue in cycle 1.
        drive_grp(1'b1, 4'b1111, 4'b0101, 4'b1000);
        tick();
        drive_grp(1'b0, '0, '0, '0);
        #1;
        chk("t1_enq", 64'(o_enq_vld), 64'd1);
        chk("t1_imm_mask", 64'(o_imm_enq_req), 64'h5);
        chk("t1_bru_mask", 64'(o_bru_enq_req), 64'h8);
        tick();
        chk("t1_rob28", 64'(o_rob_free), 64'd28);
        chk("t1_imm14", 64'(o_imm_free), 64'd14);
        chk("t1_bru15", 64'(o_bru_free), 64'd15);
        give_back();

        // Fill the branch buffer with 16 single-branch groups; the 17th stalls.
        for (int i = 0; i < 17; i++) begin
            drive_grp(1'b1, 4'b0001, 4'b0000, 4'b0001);
            tick();
        end
        drive_grp(1'b0, '0, '0, '0);
        #1;
        chk("t2_stall", 64'(o_stall), 64'd1);
        chk("t2_rdy", 64'(o_in_rdy), 64'd0);
        chk("t2_bru0", 64'(o_bru_free), 64'd0);
        tick();
        i_bru_clear_num = 3'd1;
        #1;
        chk("t2_stall_ret", 64'(o_stall), 64'd1);
        tick();
        i_bru_clear_num = 3'd0;
        #1;
        chk("t2_fire_after_ret", 64'(o_enq_vld), 64'd1);
        tick();
        give_back();

        // Bring ROB credit to 10, then fire need 4 alongside a return of 2.
        for (int i = 0; i < 7; i++) begin
            drive_grp(1'b1, (i == 5) ? 4'b0011 : 4'b1111, 4'b0000, 4'b0000);
            tick();
        end
        drive_grp(1'b0, '0, '0, '0);
        i_rob_clear_num = 3'd2;
        #1;
        chk("t3_rob10", 64'(o_rob_free), 64'd10);
        chk("t3_fire", 64'(o_enq_vld), 64'd1);
        tick();
        i_rob_clear_num = 3'd0;
        #1;
        chk("t3_rob8", 64'(o_rob_free), 64'd8);
        give_back();

        // Flush while a group is held and another is offered.
        drive_grp(1'b1, 4'b1111, 4'b0011, 4'b0001);
        tick();
        drive_grp(1'b1, 4'b0110, 4'b0100, 4'b0010);
        tick();
        drive_grp(1'b1, 4'b1010, 4'b1000, 4'b0010);
        i_flush = 1'b1;
        #1;
        chk("t4_flush_no_enq", 64'(o_enq_vld), 64'd0);
        chk("t4_flush_rdy", 64'(o_in_rdy), 64'd0);
        tick();
        i_flush = 1'b0;
        #1;
        chk("t4_drain_rdy", 64'(o_in_rdy), 64'd0);
        give_back();
        #1;
        chk("t4_full_cycle_rdy", 64'(o_in_rdy), 64'd0);
        tick();
        chk("t4_run_rdy", 64'(o_in_rdy), 64'd1);
        tick();
        drive_grp(1'b0, '0, '0, '0);
        tick();
        give_back();

        // Flush arriving in the cycle credits become full keeps DRAIN one more cycle.
        drive_grp(1'b1, 4'b1111, 4'b0000, 4'b0000);
        tick();
        drive_grp(1'b0, '0, '0, '0);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        give_back();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        chk("t5_still_drain", 64'(o_in_rdy), 64'd0);
        tick();
        chk("t5_run_again", 64'(o_in_rdy), 64'd1);

        // Asynchronous reset while a group is held and credits are in use.
        drive_grp(1'b1, 4'b1111, 4'b0000, 4'b0000);
        tick();
        drive_grp(1'b1, 4'b0011, 4'b0001, 4'b0001);
        tick();
        drive_grp(1'b0, '0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_rdy", 64'(o_in_rdy), 64'd0);
        chk("t6_rst_enq", 64'(o_enq_vld), 64'd0);
        chk("t6_rst_rob", 64'(o_rob_free), 64'd32);
        chk("t6_rst_stall", 64'(o_stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back 4-wide groups balanced by 4 ROB returns per cycle.
        fires = 0;
        stalls = 0;
        for (int i = 0; i < 42; i++) begin
            drive_grp((i <= 40) ? 1'b1 : 1'b0, 4'b1111, 4'b0000, 4'b0000);
            i_rob_clear_num = (i >= 1) ? 3'd4 : 3'd0;
            #1;
            if (o_enq_vld) fires++;
            if (o_stall) stalls++;
            tick();
        end
        drive_grp(1'b0, '0, '0, '0);
        i_rob_clear_num = 3'd0;
        chk("t7_fires", 64'(fires), 64'd41);
        chk("t7_no_stall", 64'(stalls), 64'd0);
        chk("t7_rob_full", 64'(o_rob_free), 64'd32);
`ifdef DQ_DISPATCH_PERF_EN
        chk("t7_stall_cnt", 64'(o_stall_cnt), 64'd0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
